frame_scan_controller: RTL and testbench

Sequences the per-pixel renderer over a full H_PIXELS x V_PIXELS frame and streams the rendered pixels into the framebuffer write port with valid/ready backpressure. On each frame request it snapshots the ball and paddle positions, so game-logic updates during a scan cannot tear the image. The block sits between the game-state logic, the registered renderer (1-cycle latency) and the framebuffer.

---
 rtl/pong_pkg.sv | 24 ++
 rtl/pixel_skid_fifo.sv | 46 ++++
 rtl/frame_scan_controller.sv | 185 ++++++++++++++++++
 tb/tb_frame_scan_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared geometry defaults, widths, FSM state and skid entry type
package pong_pkg;

    localparam int H_PIXELS_DEF = 320;
    localparam int V_PIXELS_DEF = 240;
    localparam int ADDR_W_DEF   = 17;
    localparam int RGB_W_DEF    = 16;
    localparam int X_W          = 9;
    localparam int Y_W          = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } scan_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [RGB_W_DEF-1:0]  rgb;
    } skid_entry_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// rtl/pixel_skid_fifo.sv - two-entry skid FIFO carrying {addr, rgb} toward the framebuffer
module pixel_skid_fifo
    import pong_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_push,
    input  skid_entry_t i_data,
    input  logic        i_pop,
    output logic [1:0]  o_count,
    output skid_entry_t o_head
);

    skid_entry_t r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic        w_do_pop;
    logic        w_do_push;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/frame_scan_controller.sv
// rtl/frame_scan_controller.sv - frame scan sequencer feeding the renderer and framebuffer; optional SCAN_INTERLACE_EN
module frame_scan_controller
    import pong_pkg::*;
#(
    parameter int H_PIXELS = H_PIXELS_DEF,
    parameter int V_PIXELS = V_PIXELS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RGB_W    = RGB_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_req,
    input  logic [X_W-1:0]    ball_x_in,
    input  logic [Y_W-1:0]    ball_y_in,
    input  logic [Y_W-1:0]    paddle_1_y_in,
    input  logic [Y_W-1:0]    paddle_2_y_in,
    output logic [X_W-1:0]    ball_x,
    output logic [Y_W-1:0]    ball_y,
    output logic [Y_W-1:0]    paddle_1_y,
    output logic [Y_W-1:0]    paddle_2_y,
    output logic [X_W-1:0]    scan_x,
    output logic [Y_W-1:0]    scan_y,
    input  logic [RGB_W-1:0]  pixel_rgb_in,
    output logic              fb_valid,
    input  logic              fb_ready,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [RGB_W-1:0]  fb_data,
`ifdef SCAN_INTERLACE_EN
    output logic              field,
`endif
    output logic              frame_busy,
    output logic              frame_done
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_PIXELS - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_PIXELS - 1);
`ifdef SCAN_INTERLACE_EN
    localparam logic [Y_W-1:0]    Y_STEP       = Y_W'(2);
    localparam logic [ADDR_W-1:0] ROW_END_STEP = ADDR_W'(H_PIXELS + 1);
`else
    localparam logic [Y_W-1:0]    Y_STEP       = Y_W'(1);
    localparam logic [ADDR_W-1:0] ROW_END_STEP = ADDR_W'(1);
`endif

    scan_state_t       r_state;
    scan_state_t       w_next_state;
    logic [X_W-1:0]    r_ball_x;
    logic [Y_W-1:0]    r_ball_y;
    logic [Y_W-1:0]    r_paddle_1_y;
    logic [Y_W-1:0]    r_paddle_2_y;
    logic [X_W-1:0]    r_scan_x;
    logic [Y_W-1:0]    r_scan_y;
    logic [ADDR_W-1:0] r_addr;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_addr;
    logic              r_busy;
    logic              r_done;

    logic              w_accept_req;
    logic              w_pop;
    logic [1:0]        w_count;
    logic [1:0]        w_count_next;
    logic              w_credit_ok;
    logic              w_issue;
    logic              w_row_end;
    logic              w_frame_end;
    logic [Y_W-1:0]    w_first_y;
    logic [ADDR_W-1:0] w_first_addr;
    logic [Y_W-1:0]    w_last_y;
    skid_entry_t       w_push_entry;
    skid_entry_t       w_head;

`ifdef SCAN_INTERLACE_EN
    logic r_field;
    logic w_field_next;

    // The field flips on frame acceptance, so the first frame after reset scans the odd rows.
    assign w_field_next = ~r_field;
    assign w_first_y    = Y_W'(w_field_next);
    assign w_first_addr = w_field_next ? ADDR_W'(H_PIXELS) : '0;
    assign w_last_y     = (Y_LAST[0] == r_field) ? Y_LAST : Y_LAST - Y_W'(1);
    assign field        = r_field;
`else
    assign w_first_y    = '0;
    assign w_first_addr = '0;
    assign w_last_y     = Y_LAST;
`endif

    assign w_accept_req = (r_state == ST_IDLE) && frame_req;
    assign w_pop        = fb_valid && fb_ready;
    assign w_count_next = w_count + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_credit_ok  = ({1'b0, w_count} + {2'b00, r_inflight}) <= (3'd1 + {2'b00, w_pop});
    assign w_issue      = ((r_state == ST_LATCH) || (r_state == ST_SCAN)) && w_credit_ok;
    assign w_row_end    = (r_scan_x == X_LAST);
    assign w_frame_end  = w_row_end && (r_scan_y == w_last_y);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:            if (frame_req) w_next_state = ST_LATCH;
            ST_LATCH, ST_SCAN:  w_next_state = (w_issue && w_frame_end) ? ST_DRAIN : ST_SCAN;
            ST_DRAIN:           if (!r_inflight && (w_count_next == 2'd0)) w_next_state = ST_DONE;
            ST_DONE:            w_next_state = ST_IDLE;
            default:            w_next_state = ST_IDLE;
        endcase
    end

    // Snapshot and counters load on the accept edge, so the LATCH cycle already
    // presents pixel 0 together with the fresh object positions.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_ball_x        <= '0;
            r_ball_y        <= '0;
            r_paddle_1_y    <= '0;
            r_paddle_2_y    <= '0;
            r_scan_x        <= '0;
            r_scan_y        <= '0;
            r_addr          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
`ifdef SCAN_INTERLACE_EN
            r_field         <= 1'b0;
`endif
        end else begin
            r_state    <= w_next_state;
            r_busy     <= (w_next_state == ST_LATCH) || (w_next_state == ST_SCAN) ||
                          (w_next_state == ST_DRAIN);
            r_done     <= (w_next_state == ST_DONE);
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_addr <= r_addr;
            end
            if (w_accept_req) begin
                r_ball_x     <= ball_x_in;
                r_ball_y     <= ball_y_in;
                r_paddle_1_y <= paddle_1_y_in;
                r_paddle_2_y <= paddle_2_y_in;
                r_scan_x     <= '0;
                r_scan_y     <= w_first_y;
                r_addr       <= w_first_addr;
`ifdef SCAN_INTERLACE_EN
                r_field      <= w_field_next;
`endif
            end else if (w_issue) begin
                if (w_row_end) begin
                    r_scan_x <= '0;
                    r_scan_y <= r_scan_y + Y_STEP;
                    r_addr   <= r_addr + ROW_END_STEP;
                end else begin
                    r_scan_x <= r_scan_x + X_W'(1);
                    r_addr   <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

    assign w_push_entry.addr = r_inflight_addr;
    assign w_push_entry.rgb  = pixel_rgb_in;

    pixel_skid_fifo u_skid (
        .clock   (clock),
        .reset   (reset),
        .i_push  (r_inflight),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign fb_valid   = (w_count != 2'd0);
    assign fb_addr    = w_head.addr;
    assign fb_data    = w_head.rgb;
    assign ball_x     = r_ball_x;
    assign ball_y     = r_ball_y;
    assign paddle_1_y = r_paddle_1_y;
    assign paddle_2_y = r_paddle_2_y;
    assign scan_x     = r_scan_x;
    assign scan_y     = r_scan_y;
    assign frame_busy = r_busy;
    assign frame_done = r_done;

endmodule

// File: tb/tb_frame_scan_controller.sv
// tb/tb_frame_scan_controller.sv - randomized scan and backpressure checks against a frame-order reference model
module tb_frame_scan_controller;

    localparam int H  = 20;
    localparam int V  = 10;
    localparam int AW = 17;
    localparam int CW = 16;
`ifdef SCAN_INTERLACE_EN
    localparam int ROWS  = V / 2;
    localparam bit ILACE = 1'b1;
`else
    localparam int ROWS  = V;
    localparam bit ILACE = 1'b0;
`endif
    localparam int NPIX = H * ROWS;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          frame_req = 1'b0;
    logic [8:0]    ball_x_in = '0;
    logic [7:0]    ball_y_in = '0;
    logic [7:0]    paddle_1_y_in = '0;
    logic [7:0]    paddle_2_y_in = '0;
    logic [8:0]    ball_x;
    logic [7:0]    ball_y;
    logic [7:0]    paddle_1_y;
    logic [7:0]    paddle_2_y;
    logic [8:0]    scan_x;
    logic [7:0]    scan_y;
    logic [CW-1:0] pixel_rgb_in = '0;
    logic          fb_valid;
    logic          fb_ready = 1'b1;
    logic [AW-1:0] fb_addr;
    logic [CW-1:0] fb_data;
    logic          frame_busy;
    logic          frame_done;
`ifdef SCAN_INTERLACE_EN
    logic          field;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          frame_no = 0;
    logic [15:0] salt = '0;
    logic [8:0]  exp_bx;
    logic [7:0]  exp_by;
    logic [7:0]  exp_p1;
    logic [7:0]  exp_p2;

    frame_scan_controller #(
        .H_PIXELS (H),
        .V_PIXELS (V),
        .ADDR_W   (AW),
        .RGB_W    (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .frame_req     (frame_req),
        .ball_x_in     (ball_x_in),
        .ball_y_in     (ball_y_in),
        .paddle_1_y_in (paddle_1_y_in),
        .paddle_2_y_in (paddle_2_y_in),
        .ball_x        (ball_x),
        .ball_y        (ball_y),
        .paddle_1_y    (paddle_1_y),
        .paddle_2_y    (paddle_2_y),
        .scan_x        (scan_x),
        .scan_y        (scan_y),
        .pixel_rgb_in  (pixel_rgb_in),
        .fb_valid      (fb_valid),
        .fb_ready      (fb_ready),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data),
`ifdef SCAN_INTERLACE_EN
        .field         (field),
`endif
        .frame_busy    (frame_busy),
        .frame_done    (frame_done)
    );

    always #5 clock = ~clock;

    // Registered renderer: colour is the pixel's linear address mixed with a per-frame salt.
    always @(posedge clock) begin
        pixel_rgb_in <= 16'(int'(scan_y) * H + int'(scan_x)) ^ salt;
    end

    function automatic int exp_addr(input int idx, input int fld);
        int row;
        row = idx / H;
        if (ILACE) row = 2 * row + fld;
        return row * H + (idx % H);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input bit rand_ball_x);
        if (rand_ball_x) ball_x_in = 9'($urandom_range(319));
        ball_y_in     = 8'($urandom_range(239));
        paddle_1_y_in = 8'($urandom_range(239));
        paddle_2_y_in = 8'($urandom_range(239));
        exp_bx = ball_x_in;
        exp_by = ball_y_in;
        exp_p1 = paddle_1_y_in;
        exp_p2 = paddle_2_y_in;
        salt = 16'($urandom);
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        frame_no++;
        chk("busy_cycle1", frame_busy, 1);
        chk("valid_cycle1", fb_valid, 0);
        chk("done_cycle1", frame_done, 0);
        step();
        chk("valid_cycle2", fb_valid, 0);
        chk("snap_ball_x", ball_x, exp_bx);
        chk("snap_ball_y", ball_y, exp_by);
        chk("snap_paddle_1", paddle_1_y, exp_p1);
        chk("snap_paddle_2", paddle_2_y, exp_p2);
`ifdef SCAN_INTERLACE_EN
        chk("field", field, 32'(frame_no % 2));
`endif
        step();
        chk("valid_cycle3", fb_valid, 1);
        chk("addr_cycle3", fb_addr, exp_addr(0, frame_no % 2));
    endtask

    task automatic scan_frame(input int ready_pct, input int stop_at, input int chg_at);
        int          idx;
        int          last_acc;
        int          fld;
        bit          stalled;
        bit          done_seen;
        logic [AW-1:0] h_addr;
        logic [CW-1:0] h_data;
        idx = 0;
        last_acc = -10;
        fld = frame_no % 2;
        stalled = 1'b0;
        done_seen = 1'b0;
        h_addr = '0;
        h_data = '0;
        for (int cyc = 0; cyc < NPIX * 30 + 100; cyc++) begin
            frame_req = 1'b0;
            if (stalled) begin
                chk("hold_valid", fb_valid, 1);
                chk("hold_addr", fb_addr, h_addr);
                chk("hold_data", fb_data, h_data);
            end
            chk("skid_le2", (dut.u_skid.o_count <= 2'd2), 1);
            chk("snap_ball_x_scan", ball_x, exp_bx);
            chk("snap_paddle_1_scan", paddle_1_y, exp_p1);
            if (frame_done) begin
                chk("done_accept_count", idx, NPIX);
                chk("done_lag", cyc - last_acc, 1);
                done_seen = 1'b1;
                frame_req = 1'b1;
                step();
                frame_req = 1'b0;
                chk("idle_busy", frame_busy, 0);
                chk("done_single_pulse", frame_done, 0);
                step();
                chk("req_in_done_ignored", frame_busy, 0);
                break;
            end
            chk("busy_scan", frame_busy, 1);
            fb_ready = ($urandom_range(99) < ready_pct);
            if (idx == chg_at) ball_x_in = 9'd200;
            if (ready_pct < 100 && $urandom_range(15) == 0) frame_req = 1'b1;
            if (fb_valid && fb_ready) begin
                chk("accept_addr", fb_addr, exp_addr(idx, fld));
                chk("accept_data", fb_data, 16'(exp_addr(idx, fld)) ^ salt);
                idx++;
                last_acc = cyc;
            end
            stalled = fb_valid && !fb_ready;
            h_addr = fb_addr;
            h_data = fb_data;
            step();
            if (stop_at >= 0 && idx >= stop_at) break;
        end
        frame_req = 1'b0;
        if (!done_seen && stop_at < 0) chk("frame_timeout", 0, 1);
    endtask

    initial begin
        #3;
        chk("rst_valid", fb_valid, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_data", fb_data, 0);
        chk("rst_busy", frame_busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_scan_x", scan_x, 0);
        chk("rst_scan_y", scan_y, 0);
        chk("rst_ball_x", ball_x, 0);
        chk("rst_paddle_2", paddle_2_y, 0);
`ifdef SCAN_INTERLACE_EN
        chk("rst_field", field, 0);
`endif
        step();
        step();
        reset = 1'b0;
        step();
        chk("idle_busy_after_rst", frame_busy, 0);

        // Frame A: full throughput, ball_x_in moves 50 -> 200 halfway through the scan
        fb_ready = 1'b1;
        ball_x_in = 9'd50;
        start_frame(1'b0);
        scan_frame(100, -1, NPIX / 2);

        // Frame B: the moved ball appears only now; 30% ready duty
        start_frame(1'b0);
        chk("snap_ball_x_200", ball_x, 200);
        scan_frame(30, -1, -1);

        // Frame C: random positions, 70% ready duty
        start_frame(1'b1);
        scan_frame(70, -1, -1);

        // Reset mid-frame while the skid is full
        fb_ready = 1'b1;
        start_frame(1'b1);
        scan_frame(100, NPIX / 3, -1);
        fb_ready = 1'b0;
        repeat (4) step();
        chk("stall_valid_before_rst", fb_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_valid", fb_valid, 0);
        chk("rst_async_busy", frame_busy, 0);
        chk("rst_async_ball_x", ball_x, 0);
        step();
        chk("rst_no_done", frame_done, 0);
        step();
        reset = 1'b0;
        frame_no = 0;
        repeat (3) begin
            step();
            chk("no_done_after_rst", frame_done, 0);
            chk("idle_after_rst", frame_busy, 0);
        end

        // Restarted frame begins at the first address again
        start_frame(1'b1);
        scan_frame(30, -1, -1);
        fb_ready = 1'b1;
        start_frame(1'b1);
        scan_frame(100, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
